jericalla_pipe: RTL
===================

// Module: jericalla_pipe
// PURPOSE
//  Parametrised successor of the Jericalla datapath: 3-stage pipeline (S0 decode/read, S1 execute/mem,
//  S2 writeback) with valid/ready instruction input, load-to-register writeback, and an immediate-load op.
//  Adds S1/S2->S0 operand forwarding and a one-cycle load-use stall. Top-level execution core; instructions
//  come from the bench or a future fetch unit.
// PARAMETERS
//  DW        32  data/register width
//  AW        5   register address width (2**AW registers); IW = 3+3*AW
//  MEM_DEPTH 32  data memory words (power of two); MW = $clog2(MEM_DEPTH)
// PORTS
//  clk       in  1   single clock, rising edge
//  rst_n     in  1   asynchronous active-low reset
//  in_valid  in  1   in_instr valid
//  in_ready  out 1   core accepts in_instr this cycle
//  in_instr  in  IW  {op[2:0], wa[AW-1:0], ra1[AW-1:0], ra2[AW-1:0]}
//  wb_valid  out 1   S2 holds a register-writing instruction
//  wb_wa     out AW  destination register in S2
//  wb_data   out DW  value being written back
// BEHAVIOUR
//  Ops: 000 NOP; 001 ADD; 010 SUB; 011 AND; 100 OR (rd wa <= ra1 op ra2);
//   101 LI: wa <= zext({ra1,ra2}) (2*AW-bit immediate); 110 SW: mem[R[ra1][MW-1:0]] <= R[ra2];
//   111 LW: wa <= mem[R[ra1][MW-1:0]]. ADD/SUB wrap mod 2**DW; address uses low MW bits only (wraps).
//  Sources read: ALU ops and SW read ra1+ra2; LW reads ra1; LI/NOP read none.
//  Register 0 reads as 0; writes to r0 are discarded (no RF update, never forwarded); still reported on wb_*.
//  Accept: transfer when in_valid & in_ready at rising edge E0; S1 captures operands+control at E0.
//  E1: S2 captures ALU result, LI immediate, or synchronous mem read data; SW writes memory at E1.
//  wb_valid/wb_wa/wb_data driven from S2 registers during the cycle after E1; RF write at E2.
//  Latency: accept edge to wb_valid = 1 cycle after E1 (2 edges); throughput 1 instr/cycle without hazards.
//  Forwarding for S0 operands, priority: S1 (non-LW writer, wa match, wa!=0) > S2 (wa match) > RF.
//   S2 forwarding covers the RF write-through case (same-cycle write/read).
//  Load-use: S1 holds LW with wa!=0 and wa equals a source of in_instr -> in_ready=0 for that cycle,
//   bubble (invalid) enters S1; next cycle the value is forwarded from S2. in_ready is combinational
//   from in_instr and S1 state; no other stall sources. in_valid=0 -> bubble enters S1.
//  NOP and SW travel the pipe but produce wb_valid=0.
//  Back-to-back SW then LW same address: LW sees new data (write at E1, read one edge later).
//  Reset (async, any time incl. mid-pipeline): S1/S2 valid cleared, wb_valid=0, wb_wa=0, wb_data=0,
//   all registers = 0, in_ready=1 after release; in-flight instructions are dropped. Memory not reset.
// STRUCTURE
//  jericalla_pkg: op encodings (OP_NOP..OP_LW), localparam helpers for IW/MW, stage-register field widths.
//  Sub-module jericalla_alu (combinational ADD/SUB/AND/OR, DW param). RF and memory inline as arrays.
// TESTING
//  1. Reset; LI r1,5; LI r2,3; ADD r3,r1,r2 back-to-back -> wb r1=5,r2=3,r3=8; in_ready stays 1.
//  2. Then SUB r4,r2,r1 -> wb r4=0xFFFFFFFE (wrap); AND r5,r1,r2 -> 1; OR r6,r1,r2 -> 7.
//  3. SW [r1]<=r3; LW r7,[r1]; ADD r8,r7,r7 -> in_ready low exactly one cycle at ADD, wb r7=8, r8=16.
//  4. LI r0,7; ADD r9,r0,r0 -> wb_valid with wb_wa=0, then r9=0; r0 read later still 0.
//  5. LI r1,1023 (max imm); SW [r1]<=r1; LW r2,[r1] -> address 1023 mod 32 =31, r2=1023; idle gaps -> no wb_valid.
//  6. Drop rst_n between edges with 2 ops in flight -> wb_valid=0 immediately; after release ADD r3,r1,r2 -> 0.

Source files
------------

// File: rtl/jericalla_pipe_pkg.sv
// jericalla_pkg: shared definitions for the Jericalla 3-stage execution core.
//   - op_e       : 3-bit opcode encodings (OP_NOP .. OP_LW)
//   - OP_W       : opcode field width inside an instruction word
//   - instr_width: instruction width for a given register-address width
//   - op_reads_ra1/op_reads_ra2/op_writes_rf/op_is_alu: decode helpers
package jericalla_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_LI  = 3'b101,
        OP_SW  = 3'b110,
        OP_LW  = 3'b111
    } op_e;

    // {op, wa, ra1, ra2}
    function automatic int unsigned instr_width(input int unsigned aw);
        return OP_W + 3 * aw;
    endfunction

    function automatic logic op_is_alu(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic op_reads_ra1(input op_e op);
        return op_is_alu(op) || (op == OP_SW) || (op == OP_LW);
    endfunction

    function automatic logic op_reads_ra2(input op_e op);
        return op_is_alu(op) || (op == OP_SW);
    endfunction

    function automatic logic op_writes_rf(input op_e op);
        return op_is_alu(op) || (op == OP_LI) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/jericalla_pipe_if.sv
// jericalla_pipe_if: instruction-input and writeback bundle of the core.
//   in_valid/in_ready/in_instr : valid/ready instruction stream into S0
//   wb_valid/wb_wa/wb_data     : S2 writeback report
//   master modport: instruction source / writeback observer
//   slave modport : the execution core
interface jericalla_pipe_if
    import jericalla_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    localparam int unsigned IW = instr_width(AW);

    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instr;
    logic          wb_valid;
    logic [AW-1:0] wb_wa;
    logic [DW-1:0] wb_data;

    modport master (
        output in_valid, in_instr,
        input  in_ready, wb_valid, wb_wa, wb_data
    );

    modport slave (
        input  in_valid, in_instr,
        output in_ready, wb_valid, wb_wa, wb_data
    );
endinterface

// File: rtl/jericalla_pipe_alu.sv
// jericalla_alu: combinational ADD/SUB/AND/OR for the execute stage.
//   op_i : opcode (non-ALU ops yield zero)
//   a_i  : first operand
//   b_i  : second operand
//   y_o  : result, ADD/SUB wrap modulo 2**DW
module jericalla_alu
    import jericalla_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  op_e           op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/jericalla_pipe.sv
// jericalla_pipe: 3-stage execution core (S0 decode/read, S1 execute/mem,
// S2 writeback) with S1/S2 operand forwarding and a one-cycle load-use stall.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (pipeline and register file)
//   bus   : slave side of jericalla_pipe_if (instruction in, writeback out)
module jericalla_pipe
    import jericalla_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned MEM_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jericalla_pipe_if.slave       bus
);

    localparam int unsigned IW   = instr_width(AW);
    localparam int unsigned MW   = $clog2(MEM_DEPTH);
    localparam int unsigned NREG = 1 << AW;

    // ---------------- state ----------------
    logic [DW-1:0] rf_q  [NREG];
    logic [DW-1:0] mem_q [MEM_DEPTH];

    logic          s1_valid_q, s1_valid_d;
    op_e           s1_op_q,    s1_op_d;
    logic [AW-1:0] s1_wa_q,    s1_wa_d;
    logic [DW-1:0] s1_a_q,     s1_a_d;
    logic [DW-1:0] s1_b_q,     s1_b_d;
    logic [DW-1:0] s1_imm_q,   s1_imm_d;

    logic          s2_valid_q, s2_valid_d;
    logic [AW-1:0] s2_wa_q,    s2_wa_d;
    logic [DW-1:0] s2_data_q,  s2_data_d;

    // ---------------- S0 decode ----------------
    logic [IW-1:0] instr;
    op_e           op_s0;
    logic [AW-1:0] wa_s0;
    logic [AW-1:0] ra_s0  [2];
    logic [DW-1:0] opnd_s0 [2];
    logic          stall;
    logic          accept;

    assign instr     = bus.in_instr;
    assign op_s0     = op_e'(instr[IW-1 -: OP_W]);
    assign wa_s0     = instr[3*AW-1 -: AW];
    assign ra_s0[0]  = instr[2*AW-1 -: AW];
    assign ra_s0[1]  = instr[AW-1:0];

    // ---------------- S1 execute ----------------
    logic [DW-1:0] alu_y;
    logic [DW-1:0] s1_res;
    logic          s1_fwd_ok;
    logic [MW-1:0] s1_addr;
    logic [DW-1:0] mem_rd;

    jericalla_alu #(.DW(DW)) u_alu (
        .op_i (s1_op_q),
        .a_i  (s1_a_q),
        .b_i  (s1_b_q),
        .y_o  (alu_y)
    );

    assign s1_res    = (s1_op_q == OP_LI) ? s1_imm_q : alu_y;
    // A load's data is not known until S2, so S1 only forwards ALU/LI results.
    assign s1_fwd_ok = s1_valid_q && (op_is_alu(s1_op_q) || (s1_op_q == OP_LI));
    assign s1_addr   = s1_a_q[MW-1:0];
    assign mem_rd    = mem_q[s1_addr];

    // Load-use: the S1 load's data is still in memory; hold S0 for one cycle.
    always_comb begin
        stall = 1'b0;
        if (s1_valid_q && (s1_op_q == OP_LW) && (s1_wa_q != '0)) begin
            if (op_reads_ra1(op_s0) && (ra_s0[0] == s1_wa_q)) stall = 1'b1;
            if (op_reads_ra2(op_s0) && (ra_s0[1] == s1_wa_q)) stall = 1'b1;
        end
    end

    assign accept       = bus.in_valid && !stall;
    assign bus.in_ready = !stall;

    // Operand select: r0 > S1 > S2 > RF. S2 also covers the cycle in which
    // the RF is being written, so the RF array needs no write-through path.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            opnd_s0[i] = rf_q[ra_s0[i]];
            if (ra_s0[i] == '0) begin
                opnd_s0[i] = '0;
            end else if (s1_fwd_ok && (s1_wa_q == ra_s0[i])) begin
                opnd_s0[i] = s1_res;
            end else if (s2_valid_q && (s2_wa_q == ra_s0[i])) begin
                opnd_s0[i] = s2_data_q;
            end
        end
    end

    always_comb begin
        s1_valid_d = accept;
        s1_op_d    = accept ? op_s0 : OP_NOP;
        s1_wa_d    = wa_s0;
        s1_a_d     = opnd_s0[0];
        s1_b_d     = opnd_s0[1];
        s1_imm_d   = DW'({ra_s0[0], ra_s0[1]});
    end

    always_comb begin
        s2_valid_d = s1_valid_q && op_writes_rf(s1_op_q);
        s2_wa_d    = s1_wa_q;
        s2_data_d  = (s1_op_q == OP_LW) ? mem_rd : s1_res;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_NOP;
            s1_wa_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_imm_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_wa_q    <= '0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_wa_q    <= s1_wa_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_imm_q   <= s1_imm_d;
            s2_valid_q <= s2_valid_d;
            s2_wa_q    <= s2_wa_d;
            s2_data_q  <= s2_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (s2_valid_q && (s2_wa_q != '0)) begin
            rf_q[s2_wa_q] <= s2_data_q;
        end
    end

    // Data memory is not reset.
    always_ff @(posedge clk) begin
        if (s1_valid_q && (s1_op_q == OP_SW)) mem_q[s1_addr] <= s1_b_q;
    end

    assign bus.wb_valid = s2_valid_q;
    assign bus.wb_wa    = s2_wa_q;
    assign bus.wb_data  = s2_data_q;

endmodule
